puf_meas_ctrl: RTL

Measurement sequencer between the serial frame receiver and the ring-oscillator PUF array inside puf_soc_top. Accepts a 40-bit challenge frame (measurement window plus two mux selects), enables and times the two RO counters, captures and compares their counts, and hands a response frame to the serial transmitter. When debug is requested, it emits a 133-bit debug frame followed by the 34-bit normal frame.

---
 rtl/puf_meas_ctrl.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/puf_meas_ctrl.sv
// Ring-oscillator PUF measurement sequencer: accepts a challenge, times the RO
// counters, compares the captured counts and hands normal/debug frames to the transmitter.
module puf_meas_ctrl #(
  parameter int unsigned CNT_BIT_SIZE = 32,
  parameter int unsigned MUX_SEL_W    = 4,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned NORM_MOD     = CNT_BIT_SIZE + 2,
  parameter int unsigned DEBUG_MOD    = 4 * CNT_BIT_SIZE + 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_start,
  input  logic                              i_op_mode,
  input  logic                              i_cfg_valid,
  input  logic [CNT_BIT_SIZE+2*MUX_SEL_W-1:0] i_cfg_data,
  output logic                              o_cfg_ready,
  output logic [MUX_SEL_W-1:0]              o_mux_sel0,
  output logic [MUX_SEL_W-1:0]              o_mux_sel1,
  output logic                              o_ro_en,
  output logic                              o_cnt_clr,
  input  logic [CNT_BIT_SIZE-1:0]           i_ro_cnt0,
  input  logic [CNT_BIT_SIZE-1:0]           i_ro_cnt1,
  output logic                              o_frame_valid,
  output logic                              o_frame_dbg,
  output logic [DEBUG_MOD-1:0]              o_frame_data,
  input  logic                              i_frame_ready,
  output logic                              o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_SEND_DBG,
    S_SEND_NORM
  } state_t;

  localparam logic [CNT_BIT_SIZE-1:0] SETTLE_LAST = CNT_BIT_SIZE'(SETTLE_CYC);
  localparam logic [CNT_BIT_SIZE-1:0] CNT_ONE     = CNT_BIT_SIZE'(1);

  state_t                    r_state;
  logic [CNT_BIT_SIZE-1:0]   r_win;
  logic [MUX_SEL_W-1:0]      r_sel0;
  logic [MUX_SEL_W-1:0]      r_sel1;
  logic [CNT_BIT_SIZE-1:0]   r_cnt;
  logic                      r_dbg_req;
  logic [NORM_MOD-1:0]       r_norm;
  logic [DEBUG_MOD-1:0]      r_frame_data;
  logic                      r_frame_dbg;
  logic                      r_frame_valid;
  logic                      r_ro_en;
  logic                      r_cnt_clr;
  logic                      r_busy;

  logic                      w_idle;
  logic                      w_accept;
  logic [CNT_BIT_SIZE-1:0]   w_win_eff;
  logic                      w_resp;
  logic                      w_ovf;
  logic [CNT_BIT_SIZE-1:0]   w_diff;
  logic [NORM_MOD-1:0]       w_norm;
  logic [DEBUG_MOD-1:0]      w_dbg_frame;
  logic                      w_dbg_now;

  assign w_idle    = (r_state == S_IDLE);
  assign w_accept  = w_idle & i_start & i_cfg_valid;
  // A zero window still enables the ROs for one cycle.
  assign w_win_eff = (r_win == '0) ? CNT_ONE : r_win;

  assign w_resp      = (i_ro_cnt0 > i_ro_cnt1);
  assign w_diff      = w_resp ? (i_ro_cnt0 - i_ro_cnt1) : (i_ro_cnt1 - i_ro_cnt0);
  assign w_ovf       = (i_ro_cnt0 == '1) | (i_ro_cnt1 == '1);
  assign w_norm      = {w_resp, w_ovf, w_diff};
  assign w_dbg_frame = {w_norm, i_ro_cnt1, i_ro_cnt0, r_win, 3'b100};
  assign w_dbg_now   = r_dbg_req | i_op_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_win         <= '0;
      r_sel0        <= '0;
      r_sel1        <= '0;
      r_cnt         <= '0;
      r_dbg_req     <= 1'b0;
      r_norm        <= '0;
      r_frame_data  <= '0;
      r_frame_dbg   <= 1'b0;
      r_frame_valid <= 1'b0;
      r_ro_en       <= 1'b0;
      r_cnt_clr     <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cnt_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_win     <= i_cfg_data[CNT_BIT_SIZE+2*MUX_SEL_W-1 -: CNT_BIT_SIZE];
            r_sel1    <= i_cfg_data[2*MUX_SEL_W-1 -: MUX_SEL_W];
            r_sel0    <= i_cfg_data[MUX_SEL_W-1:0];
            r_cnt_clr <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (i_op_mode) r_dbg_req <= 1'b1;
          r_ro_en <= 1'b1;
          r_cnt   <= CNT_ONE;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (i_op_mode) r_dbg_req <= 1'b1;
          // Counter starts at 1 so an all-ones window terminates without wrapping.
          if (r_cnt == w_win_eff) begin
            r_ro_en <= 1'b0;
            r_cnt   <= CNT_ONE;
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_SETTLE: begin
          if (i_op_mode) r_dbg_req <= 1'b1;
          if (r_cnt == SETTLE_LAST) begin
            r_state <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        S_CAPTURE: begin
          r_dbg_req     <= w_dbg_now;
          r_norm        <= w_norm;
          r_frame_valid <= 1'b1;
          if (w_dbg_now) begin
            r_frame_data <= w_dbg_frame;
            r_frame_dbg  <= 1'b1;
            r_state      <= S_SEND_DBG;
          end else begin
            r_frame_data <= {{(DEBUG_MOD-NORM_MOD){1'b0}}, w_norm};
            r_frame_dbg  <= 1'b0;
            r_state      <= S_SEND_NORM;
          end
        end
        S_SEND_DBG: begin
          if (i_frame_ready) begin
            r_frame_data <= {{(DEBUG_MOD-NORM_MOD){1'b0}}, r_norm};
            r_frame_dbg  <= 1'b0;
            r_state      <= S_SEND_NORM;
          end
        end
        S_SEND_NORM: begin
          if (i_frame_ready) begin
            r_frame_valid <= 1'b0;
            r_frame_data  <= '0;
            r_dbg_req     <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cfg_ready   = w_idle & i_start;
  assign o_mux_sel0    = r_sel0;
  assign o_mux_sel1    = r_sel1;
  assign o_ro_en       = r_ro_en;
  assign o_cnt_clr     = r_cnt_clr;
  assign o_frame_valid = r_frame_valid;
  assign o_frame_dbg   = r_frame_dbg;
  assign o_frame_data  = r_frame_data;
  assign o_busy        = r_busy;

endmodule
